// File: rtl/slice_run_ctrl.sv
// Run control ahead of the status decoder: conditions the START/PAUSE buttons,
// sequences the job FSM and counts completed slices from the cutter.

module slice_key_cond #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1, sync2;
    logic             stable, stable_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            stable   <= 1'b1;
            stable_d <= 1'b1;
            cnt      <= '0;
        end else begin
            sync1    <= key_n;
            sync2    <= sync1;
            stable_d <= stable;
            // Any return to the accepted level restarts the hold count.
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Only the press (falling) edge of the accepted level is an event.
    assign press = stable_d & ~stable;
endmodule

module slice_run_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int NUM_SLICES      = 16,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_start_n_i,
    input  logic       key_pause_n_i,
    input  logic       slice_done_i,
    output logic       start_o,
    output logic       pause_o,
    output logic       finish_o,
    output logic [4:0] slice_num_o,
    output logic       run_en_o,
    output logic [1:0] state_o
);
    localparam int NUM_KEYS = 2;
    localparam int K_START  = 0;
    localparam int K_PAUSE  = 1;
    localparam logic [4:0] NUM_MAX = 5'(NUM_SLICES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    logic [NUM_KEYS-1:0] key_n;
    logic [NUM_KEYS-1:0] press;
    state_t              state;
    logic [4:0]          slice_nxt;

    assign key_n[K_START] = key_start_n_i;
    assign key_n[K_PAUSE] = key_pause_n_i;

    genvar k;
    generate
        for (k = 0; k < NUM_KEYS; k++) begin : g_key
            slice_key_cond #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .CNT_W          (CNT_W)
            ) u_key (
                .clk  (clk),
                .rst  (rst),
                .key_n(key_n[k]),
                .press(press[k])
            );
        end
    endgenerate

    assign slice_nxt = slice_num_o + 5'd1;
    assign state_o   = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            start_o     <= 1'b0;
            pause_o     <= 1'b0;
            finish_o    <= 1'b0;
            slice_num_o <= '0;
            run_en_o    <= 1'b0;
        end else begin
            start_o  <= 1'b0;
            pause_o  <= 1'b0;
            finish_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (press[K_START]) begin
                        state       <= RUN;
                        start_o     <= 1'b1;
                        slice_num_o <= '0;
                        run_en_o    <= 1'b1;
                    end
                end
                RUN: begin
                    // The final slice beats a coincident pause; a non-final
                    // slice is still counted when pausing on the same edge.
                    if (slice_done_i && slice_nxt == NUM_MAX) begin
                        slice_num_o <= slice_nxt;
                        state       <= DONE;
                        finish_o    <= 1'b1;
                        run_en_o    <= 1'b0;
                    end else begin
                        if (slice_done_i)
                            slice_num_o <= slice_nxt;
                        if (press[K_PAUSE]) begin
                            state    <= PAUSE;
                            pause_o  <= 1'b1;
                            run_en_o <= 1'b0;
                        end
                    end
                end
                PAUSE: begin
                    if (press[K_PAUSE]) begin
                        state    <= RUN;
                        pause_o  <= 1'b1;
                        run_en_o <= 1'b1;
                    end
                end
                default: begin
                    state    <= DONE;
                    run_en_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/slice_run_ctrl.md
Name: slice_run_ctrl

Overview:
- Upstream control stage for the seven-segment status decoder.
- Conditions the raw active-low START and PAUSE pushbuttons: 2-FF synchronise, debounce, press-edge detect.
- Runs the job FSM (IDLE/RUN/PAUSE/DONE) and counts completed slices from the cutter.
- Produces the single-cycle start/pause/finish pulses and the 0..16 slice count that the display decoder consumes, plus the motor run enable.

Parameters:
- DEBOUNCE_CYCLES, 500000, clock cycles an input must hold a new level before it is accepted (10 ms at 50 MHz); must be >= 2.
- NUM_SLICES, 16, slice count at which the job finishes; range 1..31.
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- key_start_n_i  in  1  raw START button, active-low, asynchronous to clk.
- key_pause_n_i  in  1  raw PAUSE button, active-low, asynchronous to clk.
- slice_done_i  in  1  one-cycle pulse from the cutter for each completed slice; synchronous to clk.
- start_o  out  1  one-cycle pulse when the job starts.
- pause_o  out  1  one-cycle pulse on every pause toggle (RUN->PAUSE or PAUSE->RUN).
- finish_o  out  1  one-cycle pulse when the job completes.
- slice_num_o  out  5  completed slices, 0..NUM_SLICES.
- run_en_o  out  1  high only in RUN; gates the motor and cutter.
- state_o  out  2  0=IDLE, 1=RUN, 2=PAUSE, 3=DONE.

Behaviour:
- Reset (async, rst=1):
  - state IDLE; all pulse outputs 0; slice_num_o 0; run_en_o 0.
  - Synchroniser FFs and debounced levels set to 1 (released); debounce counters 0.
  - Reset mid-job aborts immediately; no finish_o is emitted.
- Synchroniser: two FFs per key. Edge 0 is the first edge that samples the raw key low. The second FF is low after edge 1.
- Debounce, per key:
  - stable register plus counter.
  - If sync2 == stable: counter clears to 0.
  - Else if counter == DEBOUNCE_CYCLES-1: stable <= sync2 and counter <= 0.
  - Else: counter increments.
  - Any bounce back to the stable level before acceptance restarts the count from 0.
- Press event: stable falls 1->0, detected against a one-cycle delayed copy of stable. Release edges generate nothing.
- Latency: with a clean press, stable falls at edge DEBOUNCE_CYCLES+1 and the output pulse is registered at edge DEBOUNCE_CYCLES+2. Each press yields exactly one event however long the key is held.
- FSM (all outputs registered):
  - IDLE: start press -> RUN; start_o=1 for one cycle; slice_num cleared to 0. Pause presses and slice_done_i are ignored.
  - RUN: slice_done_i increments slice_num.
    - If the incremented value == NUM_SLICES: go to DONE, finish_o=1 for one cycle.
    - Else, a pause press -> PAUSE with pause_o=1.
    - A start press is ignored.
  - PAUSE: pause press -> RUN with pause_o=1. slice_done_i and start presses are ignored.
  - DONE: terminal until reset. All key events and slice_done_i are ignored. slice_num_o holds NUM_SLICES.
- Simultaneous events:
  - RUN, final slice_done plus pause press: finish wins, DONE entered, no pause_o.
  - RUN, non-final slice_done plus pause press: slice is counted and PAUSE entered, in the same cycle.
- Pulse exclusivity: start_o, pause_o and finish_o are never high in the same cycle, and none is high for two consecutive cycles.
- Saturation: slice_num never exceeds NUM_SLICES and never wraps.
- run_en_o: registered, high exactly while state==RUN. It drops in the same cycle that state_o leaves RUN.

Test Plan (bench overrides DEBOUNCE_CYCLES=4, NUM_SLICES=3):
- Reset: assert rst mid-RUN with slice_num=2 -> all outputs immediately at reset values (state_o=0, slice_num_o=0, run_en_o=0). After release, the next start press behaves like power-up.
- Clean start: hold key_start_n_i low from edge 0 -> start_o high for exactly one cycle after edge 6; state_o=1; run_en_o=1. Holding the key 100 cycles gives no further pulse.
- Bounce: key_start_n_i low 3 cycles, high 1, low 3, high -> no start_o, counter restarted each time. A subsequent 10-cycle hold -> one start_o.
- Pause toggle: in RUN press PAUSE -> pause_o pulse, state_o=2, run_en_o=0. slice_done_i pulsed twice in PAUSE -> slice_num_o unchanged. Press PAUSE again -> second pause_o, state_o=1.
- Completion: three slice_done_i pulses in RUN -> slice_num_o 1,2,3. finish_o pulses on the cycle state_o becomes 3. Further slice_done_i and start presses leave slice_num_o=3 and state_o=3.
- Collision: third slice_done_i on the same edge as the pause event -> state_o=3, finish_o=1, pause_o stays 0.
